// File: rtl/lsu_if.sv
// Request, response and RAM port-2 signals of the load/store unit.
// slave is the LSU side, master the core/RAM side.
interface lsu_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic [31:0] mem_addr;
   logic [31:0] mem_rd;
   logic        mem_we;
   logic [31:0] mem_wd;

   modport slave (
      input  req_valid, req_we, req_funct3,
      input  req_addr, req_wdata, mem_rd,
      output req_ready, resp_valid, resp_rdata,
      output resp_fault, mem_addr, mem_we, mem_wd
   );

   modport master (
      output req_valid, req_we, req_funct3,
      output req_addr, req_wdata, mem_rd,
      input  req_ready, resp_valid, resp_rdata,
      input  resp_fault, mem_addr, mem_we, mem_wd
   );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit in front of a word-wide RAM port.
// Sub-word stores use read-modify-write.
module lsu #(
   parameter int unsigned MEM_SIZE   = 4096,
   parameter logic [31:0] START_ADDR = 32'd0
) (
   input  logic clk,
   input  logic rst,
   lsu_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE, ACCESS, WRITE, RESP
   } state_t;

   localparam logic [32:0] LO = {1'b0, START_ADDR};
   localparam logic [32:0] HI =
      {1'b0, START_ADDR} + 33'(MEM_SIZE) - 33'd1;

   state_t      state, nstate;
   logic        we_q, fault_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic [31:0] a_q, wdata_q, data_q;

   logic        accept, misal, illegal, oor, fault_in;
   logic [31:0] a_in, sh, loadv, mask, merged;
   logic [4:0]  bsh;

   assign accept = bus.req_valid && state == IDLE && !rst;
   assign a_in   = {bus.req_addr[31:2], 2'b00};
   assign bus.mem_addr = a_q;

   always_comb begin
      misal   = 1'b0;
      illegal = 1'b0;
      unique case (bus.req_funct3)
         3'b000, 3'b100: misal = 1'b0;
         3'b001, 3'b101: misal = bus.req_addr[0];
         3'b010:         misal = |bus.req_addr[1:0];
         default:        illegal = 1'b1;
      endcase
      if (bus.req_funct3[2] && bus.req_we)
         illegal = 1'b1;
   end

   // 33-bit compare so addresses near 2^32 cannot wrap into range
   assign oor = ({1'b0, a_in} < LO) ||
                ({1'b0, a_in} + 33'd3 > HI);
   assign fault_in = misal || illegal || oor;

   assign bsh = {off_q, 3'b000};
   assign sh  = bus.mem_rd >> bsh;

   always_comb begin
      unique case (f3_q)
         3'b000:  loadv = {{24{sh[7]}}, sh[7:0]};
         3'b100:  loadv = {24'd0, sh[7:0]};
         3'b001:  loadv = {{16{sh[15]}}, sh[15:0]};
         3'b101:  loadv = {16'd0, sh[15:0]};
         default: loadv = sh;
      endcase
   end

   assign mask = (f3_q[1:0] == 2'b00) ?
                 (32'h0000_00ff << bsh) :
                 (32'h0000_ffff << bsh);
   assign merged = (bus.mem_rd & ~mask) |
                   ((wdata_q << bsh) & mask);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate         = state;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_fault = 1'b0;
      bus.resp_rdata = 32'd0;
      bus.mem_we     = 1'b0;
      bus.mem_wd     = 32'd0;
      unique case (state)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (accept)
               nstate = fault_in ? RESP : ACCESS;
         end
         ACCESS: begin
            if (we_q && f3_q == 3'b010) begin
               bus.mem_we = 1'b1;
               bus.mem_wd = wdata_q;
               nstate     = RESP;
            end else if (we_q) begin
               nstate = WRITE;
            end else begin
               nstate = RESP;
            end
         end
         WRITE: begin
            bus.mem_we = 1'b1;
            bus.mem_wd = data_q;
            nstate     = RESP;
         end
         RESP: begin
            bus.resp_valid = 1'b1;
            bus.resp_fault = fault_q;
            if (!we_q && !fault_q)
               bus.resp_rdata = data_q;
            nstate = IDLE;
         end
         default: nstate = IDLE;
      endcase
      if (rst) begin
         nstate         = IDLE;
         bus.req_ready  = 1'b0;
         bus.resp_valid = 1'b0;
         bus.resp_fault = 1'b0;
         bus.resp_rdata = 32'd0;
         bus.mem_we     = 1'b0;
         bus.mem_wd     = 32'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q    <= 1'b0;
         fault_q <= 1'b0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         a_q     <= 32'd0;
         wdata_q <= 32'd0;
         data_q  <= 32'd0;
      end else begin
         if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            off_q   <= bus.req_addr[1:0];
            wdata_q <= bus.req_wdata;
            fault_q <= fault_in;
            if (!fault_in) a_q <= a_in;
         end
         // loads keep the extended value, sub-word stores the merged word
         if (state == ACCESS)
            data_q <= we_q ? merged : loadv;
      end
   end

endmodule
